// File: rtl/prf_free_list.sv
// Physical register free list: a circular buffer of free indices with a write tail,
// a speculative head for rename and a committed head that flushes roll back to.
module prf_free_list #(
  parameter int PRF_SIZE    = 64,
  parameter int ARF_SIZE    = 32,
  parameter int ALLOC_WIDTH = 2,
  parameter int FREE_WIDTH  = 2,
  parameter int INDEX_SIZE  = $clog2(PRF_SIZE)
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  clear,
  input  logic [ALLOC_WIDTH-1:0]                alloc_req,
  output logic                                  alloc_ready,
  output logic [ALLOC_WIDTH-1:0][INDEX_SIZE-1:0] alloc_index,
  input  logic [FREE_WIDTH-1:0]                 retire_valid,
  input  logic [FREE_WIDTH-1:0]                 free_valid,
  input  logic [FREE_WIDTH-1:0][INDEX_SIZE-1:0] free_index,
  output logic [INDEX_SIZE:0]                   free_count,
  output logic                                  error
);

  // Handshake: alloc_ready depends only on registered state, alloc_req and clear.
  // A grant happens in a cycle where alloc_ready is high and alloc_req is non-zero,
  // and it covers every requesting lane (all-or-nothing). While alloc_ready is low
  // nothing is consumed and alloc_req may change freely.

  typedef logic [INDEX_SIZE:0] ptr_t;

  ptr_t                  tail_q, spec_head_q, commit_head_q;
  logic                  error_q;
  logic [INDEX_SIZE-1:0] entries [PRF_SIZE];

  ptr_t alloc_cnt, free_cnt, retire_cnt;
  ptr_t alloc_ptr [ALLOC_WIDTH];
  ptr_t free_ptr  [FREE_WIDTH];
  ptr_t tail_n, spec_head_n, commit_head_n, occupancy_n, spec_ahead;
  logic alloc_fire, overflow, retire_over;

  // Lane slots are packed: lane i uses the slot after all lower requesting lanes.
  always_comb begin
    alloc_cnt = '0;
    for (int i = 0; i < ALLOC_WIDTH; i++) begin
      alloc_ptr[i] = spec_head_q + alloc_cnt;
      if (alloc_req[i]) alloc_cnt = alloc_cnt + ptr_t'(1);
    end
  end

  always_comb begin
    free_cnt = '0;
    for (int j = 0; j < FREE_WIDTH; j++) begin
      free_ptr[j] = tail_q + free_cnt;
      if (free_valid[j]) free_cnt = free_cnt + ptr_t'(1);
    end
  end

  always_comb begin
    retire_cnt = '0;
    for (int j = 0; j < FREE_WIDTH; j++) begin
      if (retire_valid[j]) retire_cnt = retire_cnt + ptr_t'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < ALLOC_WIDTH; i++) begin
      alloc_index[i] = entries[alloc_ptr[i][INDEX_SIZE-1:0]];
    end
  end

  assign free_count  = tail_q - spec_head_q;
  assign alloc_ready = (free_count >= alloc_cnt) && !clear;
  assign alloc_fire  = alloc_ready && (|alloc_req);
  assign error       = error_q;

  always_comb begin
    tail_n        = tail_q + free_cnt;
    commit_head_n = commit_head_q + retire_cnt;
    spec_head_n   = spec_head_q;
    if (clear)           spec_head_n = commit_head_n;
    else if (alloc_fire) spec_head_n = spec_head_q + alloc_cnt;
    occupancy_n = tail_n - commit_head_n;
    spec_ahead  = spec_head_q - commit_head_q;
    overflow    = occupancy_n > ptr_t'(PRF_SIZE);
    retire_over = retire_cnt > spec_ahead;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tail_q        <= ptr_t'(PRF_SIZE - ARF_SIZE);
      spec_head_q   <= '0;
      commit_head_q <= '0;
      error_q       <= 1'b0;
      // Only the first PRF_SIZE-ARF_SIZE slots matter; the rest are overwritten by frees.
      for (int k = 0; k < PRF_SIZE; k++) begin
        entries[k] <= INDEX_SIZE'(ARF_SIZE + k);
      end
    end else begin
      tail_q        <= tail_n;
      spec_head_q   <= spec_head_n;
      commit_head_q <= commit_head_n;
      if (overflow || retire_over) error_q <= 1'b1;
      for (int j = 0; j < FREE_WIDTH; j++) begin
        if (free_valid[j]) entries[free_ptr[j][INDEX_SIZE-1:0]] <= free_index[j];
      end
    end
  end

endmodule

// File: tb/tb_prf_free_list.sv
// Bench for prf_free_list: directed scenarios with literal checks, plus a queue-based
// model of the free list compared against the DUT on every non-reset cycle.
module tb_prf_free_list;
  localparam int PRF = 64;
  localparam int ARF = 32;
  localparam int IW  = 6;

  logic              clock = 1'b0;
  logic              reset, clear;
  logic [1:0]        alloc_req, retire_valid, free_valid;
  logic [1:0][IW-1:0] free_index, alloc_index;
  logic              alloc_ready, error;
  logic [IW:0]       free_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Clock / reset
  always #5 clock = ~clock;

  prf_free_list #(
    .PRF_SIZE(PRF), .ARF_SIZE(ARF), .ALLOC_WIDTH(2), .FREE_WIDTH(2), .INDEX_SIZE(IW)
  ) dut (
    .clock(clock), .reset(reset), .clear(clear),
    .alloc_req(alloc_req), .alloc_ready(alloc_ready), .alloc_index(alloc_index),
    .retire_valid(retire_valid), .free_valid(free_valid), .free_index(free_index),
    .free_count(free_count), .error(error)
  );

  // Scoreboard model: exp_q holds the free entries from the committed head to the tail,
  // spec_off counts speculatively handed-out entries at its front.
  logic [IW-1:0] exp_q[$];
  int            spec_off;
  logic          model_err;

  function automatic int pc2(logic [1:0] v);
    return int'(v[0]) + int'(v[1]);
  endfunction

  task automatic check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int k = 0; k < PRF - ARF; k++) exp_q.push_back(IW'(ARF + k));
    spec_off  = 0;
    model_err = 1'b0;
  endtask

  always @(negedge clock) begin
    int   avail, nreq, off, cur, nret;
    logic exp_ready;
    if (reset) begin
      model_reset();
    end else begin
      avail     = exp_q.size() - spec_off;
      nreq      = pc2(alloc_req);
      exp_ready = (avail >= nreq) && !clear;
      check("cmp_free_count", int'(free_count), avail);
      check("cmp_alloc_ready", int'(alloc_ready), int'(exp_ready));
      check("cmp_error", int'(error), int'(model_err));
      if (exp_ready && nreq > 0 && exp_q.size() <= PRF && spec_off >= 0) begin
        off = spec_off;
        for (int i = 0; i < 2; i++) begin
          if (alloc_req[i]) begin
            check($sformatf("cmp_alloc_index%0d", i), int'(alloc_index[i]), int'(exp_q[off]));
            off++;
          end
        end
      end
      cur = spec_off;
      if (exp_ready) spec_off += nreq;
      nret = pc2(retire_valid);
      if (nret > cur) model_err = 1'b1;
      for (int r = 0; r < nret; r++) if (exp_q.size() > 0) void'(exp_q.pop_front());
      spec_off -= nret;
      if (clear) spec_off = 0;
      for (int j = 0; j < 2; j++) if (free_valid[j]) exp_q.push_back(free_index[j]);
      if (exp_q.size() > PRF) model_err = 1'b1;
    end
  end

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic drive(logic [1:0] a, logic [1:0] r, logic [1:0] f,
                       logic [IW-1:0] fi0, logic [IW-1:0] fi1, logic c);
    alloc_req     = a;
    retire_valid  = r;
    free_valid    = f;
    free_index[0] = fi0;
    free_index[1] = fi1;
    clear         = c;
    #1;
  endtask

  task automatic idle();
    drive(2'b00, 2'b00, 2'b00, '0, '0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
  endtask

  logic [1:0] pat [5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         outst;
    logic [1:0] a, rv;
    logic       c;
    pat[0] = 2'b11; pat[1] = 2'b01; pat[2] = 2'b10; pat[3] = 2'b11; pat[4] = 2'b00;

    // Reset state
    do_reset();
    idle();
    check("reset_free_count", int'(free_count), 32);
    check("reset_error", int'(error), 0);
    check("reset_alloc_ready", int'(alloc_ready), 1);
    tick();

    // Dual allocation right after reset
    drive(2'b11, 2'b00, 2'b00, '0, '0, 1'b0);
    check("dual_lane0", int'(alloc_index[0]), 32);
    check("dual_lane1", int'(alloc_index[1]), 33);
    check("dual_ready", int'(alloc_ready), 1);
    tick();
    idle();
    check("dual_free_count", int'(free_count), 30);
    tick();

    // Single-lane packing: lane 1 alone, then lane 0 alone
    do_reset();
    drive(2'b10, 2'b00, 2'b00, '0, '0, 1'b0);
    check("lane1_only", int'(alloc_index[1]), 32);
    tick();
    drive(2'b01, 2'b00, 2'b00, '0, '0, 1'b0);
    check("lane0_after", int'(alloc_index[0]), 33);
    tick();
    idle();
    check("packing_free_count", int'(free_count), 30);
    tick();

    // Nearly empty: refuse, accept a free, then grant with the freed index (no bypass)
    do_reset();
    for (int i = 0; i < 15; i++) begin
      drive(2'b11, 2'b00, 2'b00, '0, '0, 1'b0);
      tick();
    end
    drive(2'b01, 2'b00, 2'b00, '0, '0, 1'b0);
    tick();
    drive(2'b11, 2'b00, 2'b01, 6'd5, '0, 1'b0);
    check("empty_ready", int'(alloc_ready), 0);
    check("empty_free_count", int'(free_count), 1);
    tick();
    drive(2'b11, 2'b00, 2'b00, '0, '0, 1'b0);
    check("refill_free_count", int'(free_count), 2);
    check("refill_ready", int'(alloc_ready), 1);
    check("refill_lane0", int'(alloc_index[0]), 63);
    check("refill_lane1", int'(alloc_index[1]), 5);
    tick();
    idle();
    check("drained_free_count", int'(free_count), 0);
    tick();

    // Flush rolls the speculative head back to the committed head
    do_reset();
    drive(2'b11, 2'b00, 2'b00, '0, '0, 1'b0);
    tick();
    drive(2'b11, 2'b00, 2'b00, '0, '0, 1'b0);
    tick();
    drive(2'b00, 2'b01, 2'b00, '0, '0, 1'b0);
    tick();
    drive(2'b00, 2'b00, 2'b00, '0, '0, 1'b1);
    check("clear_ready", int'(alloc_ready), 0);
    tick();
    drive(2'b01, 2'b00, 2'b00, '0, '0, 1'b0);
    check("post_clear_lane0", int'(alloc_index[0]), 33);
    check("post_clear_free_count", int'(free_count), 31);
    tick();
    idle();
    tick();

    // Long mixed traffic wrapping all pointers several times, with a flush midway
    do_reset();
    outst = 0;
    for (int i = 0; i < 200; i++) begin
      a  = pat[i % 5];
      rv = (outst >= 2) ? 2'b11 : (outst == 1) ? 2'b01 : 2'b00;
      c  = (i == 100);
      drive(a, rv, rv, IW'((i * 7) % 64), IW'((i * 7 + 1) % 64), c);
      tick();
      if (c) outst = 0;
      else   outst = outst + pc2(a) - pc2(rv);
    end
    idle();
    check("wrap_error", int'(error), 0);
    tick();

    // Retiring past the speculative head is flagged
    do_reset();
    drive(2'b00, 2'b01, 2'b00, '0, '0, 1'b0);
    tick();
    idle();
    check("retire_over_error", int'(error), 1);
    tick();

    // Over-freeing: 16 dual frees fill to exactly PRF_SIZE, the 17th overflows
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(2'b00, 2'b00, 2'b11, IW'(i), IW'(i + 16), 1'b0);
      tick();
    end
    idle();
    check("full_error", int'(error), 0);
    check("full_free_count", int'(free_count), 64);
    drive(2'b00, 2'b00, 2'b11, 6'd1, 6'd2, 1'b0);
    tick();
    idle();
    check("overflow_error", int'(error), 1);
    check("overflow_free_count", int'(free_count), 66);
    tick();
    tick();
    tick();
    check("overflow_sticky", int'(error), 1);
    do_reset();
    idle();
    check("reset_clears_error", int'(error), 0);
    check("reset_free_count_again", int'(free_count), 32);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
